keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner, ROWS x COLS, successor to the fixed 4x4 scanner.
- Drives one active-low row at a time and samples the active-low column inputs through a synchroniser.
- Debounces every key individually and reports both press and release events.
- Events go through a small FIFO with a valid/ready handshake, consumed by the game-control logic (paddle up/down, start).

Parameters:
- ROWS, 4, number of row lines driven (>=2).
- COLS, 4, number of column lines sampled (>=2).
- SETTLE_CYCLES, 512, clk cycles a row is held before its columns are sampled (>=3).
- DEBOUNCE_SCANS, 3, consecutive identical differing samples required to change a key's state (>=1).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).
- KW (derived), clog2(ROWS*COLS), key index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cols  in  COLS  column lines, active-low (0 = key in the driven row is pressed), pulled up externally.
- rows  out  ROWS  row drive; exactly one bit is 0 at any time.
- event_valid  out  1  FIFO head holds an event.
- event_ready  in  1  consumer accepts the head event this cycle.
- event_code  out  KW  key index = row*COLS + col.
- event_press  out  1  1 = press, 0 = release.
- key_state  out  ROWS*COLS  debounced state, bit k = 1 while key k is held.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Synchroniser: cols passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- Scan FSM states:
  - SETTLE: counter runs 0..SETTLE_CYCLES-1, then go to SAMPLE.
  - SAMPLE: 1 cycle; capture ~cols_sync into row_sample, then go to UPDATE.
  - UPDATE: COLS cycles; column c is processed in cycle c, then go to NEXT.
  - NEXT: 1 cycle; row index r <= (r == ROWS-1) ? 0 : r+1; rows <= ~(1<<next r); return to SETTLE.
  - Row period = SETTLE_CYCLES + COLS + 2 cycles. Frame = ROWS x row period.
- Debounce, per key k = r*COLS + c, applied in its UPDATE cycle:
  - raw == key_state[k]: dbc[k] <= 0.
  - raw != key_state[k] and dbc[k] == DEBOUNCE_SCANS-1: key_state[k] <= raw, dbc[k] <= 0, push event {k, raw}.
  - Otherwise: dbc[k] increments.
  - A change is therefore reported on the DEBOUNCE_SCANS-th consecutive frame in which it is seen. A bounce resets the count.
- No ghost or rollover masking; every debounced transition is reported.
- FIFO (show-ahead):
  - event_valid = !empty. event_code and event_press are the head entry and stay stable while valid && !ready.
  - A pop happens on valid && ready.
  - Push with pop in the same cycle while full: both take effect, nothing is dropped.
  - Push while full without pop: the event is discarded, overflow <= 1, key_state still updates.
  - Events leave in generation order.
- overflow: clr_overflow clears it, but a drop in the same cycle takes priority and sets it.
- Reset values:
  - rows = ~1 (row 0 active), FSM in SETTLE with counter 0, row index 0.
  - key_state = 0, all dbc = 0, synchroniser flops = all ones.
  - FIFO empty, event_valid = 0, event_code = 0, event_press = 0, overflow = 0.
- Reset mid-scan or with a non-empty FIFO: everything returns to the reset values; pending events are lost; no release events are generated for held keys.
- Latency: a clean press reaches event_valid 1 cycle after the UPDATE cycle of the confirming frame.

Test Plan (ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; row period 10, frame 40):
- Reset, then idle for 200 cycles -> rows cycles 1110, 1101, 1011, 0111 with each row held 10 cycles; event_valid stays 0; key_state = 0.
- Hold row1/col2 low from cycle 0, event_ready = 1 -> exactly one event, code 6, press 1, in the 3rd frame; key_state[6] = 1. Release -> code 6, press 0, after 3 frames.
- Press row1/col2 for 1 frame only, or alternate pressed/released every frame -> no event, key_state[6] stays 0.
- event_ready = 0, press keys 0, 5, 10, 15 and 3 -> 4 events queued, overflow = 1. Then ready = 1 -> codes drain in order of generation, key 3's event is absent, key_state[3] = 1. Pulse clr_overflow -> overflow = 0.
- FIFO full and ready = 1 in the cycle a new event is pushed -> the head pops, the new event is stored, overflow stays 0.
- Assert rst during UPDATE with 2 events queued and key 6 held -> next cycle event_valid = 0, rows = 1110, key_state = 0; key 6 is reported as a press again 3 frames later.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one active-low row at a time and debounces every key on its own.
// Confirmed press/release events are queued in a small show-ahead FIFO for the consumer.
module keypad_scanner #(
    parameter int  ROWS           = 4,
    parameter int  COLS           = 4,
    parameter int  SETTLE_CYCLES  = 512,
    parameter int  DEBOUNCE_SCANS = 3,
    parameter int  FIFO_DEPTH     = 4,
    localparam int KW             = $clog2(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      cols,
    output logic [ROWS-1:0]      rows,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [KW-1:0]        event_code,
    output logic                 event_press,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int NK   = ROWS * COLS;
    localparam int RW   = $clog2(ROWS);
    localparam int CLW  = $clog2(COLS);
    localparam int CMAX = (SETTLE_CYCLES > COLS) ? SETTLE_CYCLES : COLS;
    localparam int CW   = $clog2(CMAX);
    localparam int DW   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = KW + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);
    localparam logic [DW-1:0] DBC_LAST    = DW'(DEBOUNCE_SCANS - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_SAMPLE,
        S_UPDATE,
        S_NEXT
    } scan_state_e;

    scan_state_e         state_q, state_d;
    logic [COLS-1:0]     col_meta_q, col_sync_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       row_idx_q, row_idx_d, row_next;
    logic [ROWS-1:0]     rows_q, rows_d;
    logic [COLS-1:0]     row_sample_q, row_sample_d;
    logic [NK-1:0]       key_state_q, key_state_d;
    logic [DW-1:0]       dbc_q [NK];
    logic [DW-1:0]       dbc_d [NK];
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       mem_d [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;

    logic [CLW-1:0]      col_idx;
    logic [KW-1:0]       key_idx;
    logic                raw;
    logic                push;
    logic                fifo_empty, fifo_full, pop, do_push, drop;

    assign col_idx  = cnt_q[CLW-1:0];
    assign key_idx  = KW'(row_idx_q) * KW'(COLS) + KW'(col_idx);
    assign raw      = row_sample_q[col_idx];
    assign row_next = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + 1'b1;

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_UPDATE;
            S_UPDATE: if (cnt_q == COL_LAST) state_d = S_NEXT;
            S_NEXT:   state_d = S_SETTLE;
            default:  state_d = S_SETTLE;
        endcase
    end

    // Scan outputs: counter, row drive, sampling and per-key debounce
    always_comb begin
        cnt_d        = cnt_q;
        row_idx_d    = row_idx_q;
        rows_d       = rows_q;
        row_sample_d = row_sample_q;
        key_state_d  = key_state_q;
        dbc_d        = dbc_q;
        push         = 1'b0;
        case (state_q)
            S_SETTLE: cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
            S_SAMPLE: begin
                row_sample_d = ~col_sync_q;
                cnt_d        = '0;
            end
            S_UPDATE: begin
                cnt_d = (cnt_q == COL_LAST) ? '0 : cnt_q + 1'b1;
                if (raw == key_state_q[key_idx]) begin
                    dbc_d[key_idx] = '0;
                end else if (dbc_q[key_idx] == DBC_LAST) begin
                    key_state_d[key_idx] = raw;
                    dbc_d[key_idx]       = '0;
                    push                 = 1'b1;
                end else begin
                    dbc_d[key_idx] = dbc_q[key_idx] + 1'b1;
                end
            end
            S_NEXT: begin
                row_idx_d = row_next;
                rows_d    = ~(ROWS'(1) << row_next);
                cnt_d     = '0;
            end
            default: cnt_d = '0;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop        = !fifo_empty && event_ready;
    assign do_push    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {key_idx, raw};
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q   <= '1;
            col_sync_q   <= '1;
            cnt_q        <= '0;
            row_idx_q    <= '0;
            rows_q       <= ~ROWS'(1);
            row_sample_q <= '0;
            key_state_q  <= '0;
            for (int i = 0; i < NK; i++) dbc_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            col_meta_q   <= cols;
            col_sync_q   <= col_meta_q;
            cnt_q        <= cnt_d;
            row_idx_q    <= row_idx_d;
            rows_q       <= rows_d;
            row_sample_q <= row_sample_d;
            key_state_q  <= key_state_d;
            dbc_q        <= dbc_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rows                      = rows_q;
    assign key_state                 = key_state_q;
    assign overflow                  = overflow_q;
    assign event_valid               = !fifo_empty;
    assign {event_code, event_press} = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (4x4, settle 4, debounce 3, FIFO 4): row period 10, frame 40.
// A small keypad model pulls column lines low for pressed keys in the driven row.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_code;
    logic        event_press;
    logic [15:0] key_state;
    logic        overflow;
    logic        clr_overflow;

    logic [15:0] keys;
    int          cyc;
    int          checks;
    int          errors;
    logic [4:0]  got_q[$];
    int          got_cyc_q[$];
    logic [4:0]  exp_q[$];

    keypad_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cols         (cols),
        .rows         (rows),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_code   (event_code),
        .event_press  (event_press),
        .key_state    (key_state),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Clock and cycle count (cycle 0 = first cycle out of reset)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always_comb begin
        cols = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (rows[r] == 1'b0 && keys[r*4+c]) cols[c] = 1'b0;
    end

    // Every accepted event, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && event_valid && event_ready) begin
            got_q.push_back({event_code, event_press});
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [15:0] k);
        rst = 1'b1;
        keys = k;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff_ffff, 32'(exp_q[i]));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        event_ready  = 1'b0;
        clr_overflow = 1'b0;
        keys         = '0;

        // Reset values and idle scanning
        do_reset(16'h0000);
        chk("rst_valid", event_valid, 1'b0);
        chk("rst_code", event_code, 4'd0);
        chk("rst_press", event_press, 1'b0);
        chk("rst_key_state", key_state, 16'h0000);
        chk("rst_overflow", overflow, 1'b0);
        for (int k = 0; k < 200; k++) begin
            logic [3:0] exp_rows;
            goto_cyc(k);
            exp_rows = ~(4'b0001 << ((k / 10) % 4));
            chk($sformatf("idle_rows_c%0d", k), rows, exp_rows);
            chk($sformatf("idle_valid_c%0d", k), event_valid, 1'b0);
        end
        chk("idle_key_state", key_state, 16'h0000);

        // Clean press and release of key 6 (row 1, col 2)
        do_reset(16'h0040);
        event_ready = 1'b1;
        goto_cyc(97);
        chk("press_not_early", event_valid, 1'b0);
        chk("press_state_early", key_state, 16'h0000);
        goto_cyc(98);
        chk("press_valid", event_valid, 1'b1);
        chk("press_code", event_code, 4'd6);
        chk("press_dir", event_press, 1'b1);
        chk("press_state", key_state, 16'h0040);
        goto_cyc(99);
        chk("press_popped", event_valid, 1'b0);
        goto_cyc(100);
        keys = 16'h0000;
        goto_cyc(217);
        chk("release_not_early", event_valid, 1'b0);
        chk("release_state_held", key_state, 16'h0040);
        goto_cyc(218);
        chk("release_valid", event_valid, 1'b1);
        chk("release_code", event_code, 4'd6);
        chk("release_dir", event_press, 1'b0);
        chk("release_state", key_state, 16'h0000);
        goto_cyc(230);
        exp_q.push_back({4'd6, 1'b1});
        exp_q.push_back({4'd6, 1'b0});
        check_events("press_release");
        chk("press_cycle", (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1, 98);
        chk("release_cycle", (got_cyc_q.size() > 1) ? got_cyc_q[1] : -1, 218);

        // Bouncing key 6: one-frame press, then alternating frames
        do_reset(16'h0040);
        event_ready = 1'b1;
        goto_cyc(40);  keys = 16'h0000;
        goto_cyc(80);  keys = 16'h0040;
        goto_cyc(98);
        chk("bounce_no_event", event_valid, 1'b0);
        goto_cyc(120); keys = 16'h0000;
        goto_cyc(160); keys = 16'h0040;
        goto_cyc(200); keys = 16'h0000;
        goto_cyc(250);
        check_events("bounce");
        chk("bounce_state", key_state, 16'h0000);

        // Overflow: keys 0,5,10,15 fill the FIFO, key 3 is dropped
        do_reset(16'h8421);
        event_ready = 1'b0;
        goto_cyc(86);
        chk("ovf_first_valid", event_valid, 1'b1);
        chk("ovf_first_code", event_code, 4'd0);
        goto_cyc(119);
        chk("ovf_state4", key_state, 16'h8421);
        chk("ovf_not_yet", overflow, 1'b0);
        goto_cyc(120);
        keys = 16'h8429;
        goto_cyc(150);
        chk("ovf_head_stable", event_code, 4'd0);
        chk("ovf_head_press", event_press, 1'b1);
        goto_cyc(208);
        chk("ovf_before_drop", overflow, 1'b0);
        goto_cyc(209);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_key3_state", key_state, 16'h8429);
        chk("ovf_head_after", event_code, 4'd0);
        goto_cyc(210);
        event_ready = 1'b1;
        goto_cyc(215);
        chk("ovf_drained", event_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        exp_q.push_back({4'd0, 1'b1});
        exp_q.push_back({4'd5, 1'b1});
        exp_q.push_back({4'd10, 1'b1});
        exp_q.push_back({4'd15, 1'b1});
        check_events("ovf_order");
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Full FIFO with pop in the push cycle: nothing lost
        do_reset(16'h8421);
        event_ready = 1'b0;
        goto_cyc(120);
        keys = 16'h8429;
        goto_cyc(208);
        chk("fullpop_valid", event_valid, 1'b1);
        chk("fullpop_head", event_code, 4'd0);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        chk("fullpop_no_ovf", overflow, 1'b0);
        chk("fullpop_next_head", event_code, 4'd5);
        chk("fullpop_state", key_state, 16'h8429);
        event_ready = 1'b1;
        goto_cyc(220);
        chk("fullpop_empty", event_valid, 1'b0);
        exp_q.push_back({4'd0, 1'b1});
        exp_q.push_back({4'd5, 1'b1});
        exp_q.push_back({4'd10, 1'b1});
        exp_q.push_back({4'd15, 1'b1});
        exp_q.push_back({4'd3, 1'b1});
        check_events("fullpop_order");
        chk("fullpop_ovf_end", overflow, 1'b0);

        // Reset during UPDATE with two events queued and key 6 part-way through debounce
        do_reset(16'h0021);
        event_ready = 1'b0;
        goto_cyc(60);
        keys = 16'h0061;
        goto_cyc(125);
        chk("midrst_pre_valid", event_valid, 1'b1);
        chk("midrst_pre_state", key_state, 16'h0021);
        rst  = 1'b1;
        keys = 16'h0040;
        tick();
        rst = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        chk("midrst_valid", event_valid, 1'b0);
        chk("midrst_rows", rows, 4'b1110);
        chk("midrst_state", key_state, 16'h0000);
        chk("midrst_code", event_code, 4'd0);
        event_ready = 1'b1;
        goto_cyc(97);
        chk("midrst_no_early", event_valid, 1'b0);
        goto_cyc(98);
        chk("midrst_press_valid", event_valid, 1'b1);
        chk("midrst_press_code", event_code, 4'd6);
        chk("midrst_press_dir", event_press, 1'b1);
        goto_cyc(110);
        exp_q.push_back({4'd6, 1'b1});
        check_events("midrst_events");
        chk("midrst_final_state", key_state, 16'h0040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
